// File: rtl/tpu_pkg.sv
// Shared types and latency defaults for the TPU tile sequencer.
package tpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREQ,
    ST_WLOAD,
    ST_FEED,
    ST_DRAIN,
    ST_FINISH
  } seq_state_e;

  localparam int unsigned DEF_MATRIX_SIZE = 8;

  // UB address issue to result row valid at the result SRAM input.
  function automatic int unsigned pipe_lat_of(input int unsigned matrix_size);
    return 2 * matrix_size + 2;
  endfunction

  function automatic int unsigned wload_lat_of(input int unsigned matrix_size);
    return matrix_size;
  endfunction

endpackage

// File: rtl/tpu_tile_sequencer_if.sv
// Control, weight-FIFO, unified-buffer and result-SRAM signals of the tile sequencer.
interface tpu_tile_sequencer_if #(
  parameter int unsigned ADDRESSSIZE = 10,
  parameter int unsigned TILE_BW     = 6
);
  logic                   start;
  logic [ADDRESSSIZE-1:0] cfg_ub_base;
  logic [ADDRESSSIZE-1:0] cfg_res_base;
  logic [ADDRESSSIZE-1:0] cfg_num_vec;
  logic [TILE_BW-1:0]     cfg_num_tiles;
  logic                   fifo_empty;
  logic                   fifo_read_enable;
  logic                   we_rl;
  logic [ADDRESSSIZE-1:0] ub_address;
  logic                   res_write_enable;
  logic [ADDRESSSIZE-1:0] res_address;
  logic                   busy;
  logic                   done;
  logic                   cfg_err;

  modport master (
    input  start, cfg_ub_base, cfg_res_base, cfg_num_vec, cfg_num_tiles, fifo_empty,
    output fifo_read_enable, we_rl, ub_address, res_write_enable, res_address,
           busy, done, cfg_err
  );

  modport slave (
    output start, cfg_ub_base, cfg_res_base, cfg_num_vec, cfg_num_tiles, fifo_empty,
    input  fifo_read_enable, we_rl, ub_address, res_write_enable, res_address,
           busy, done, cfg_err
  );
endinterface

// File: rtl/tpu_valid_pipe.sv
// Fixed-depth valid shift register tracking result rows in flight through the array.
module tpu_valid_pipe #(
  parameter int unsigned DEPTH = 18
) (
  input  logic clk,
  input  logic rstn,
  input  logic in_valid,
  output logic out_valid,
  output logic any_valid
);
  logic [DEPTH-1:0] pipe_q, pipe_d;

  always_comb pipe_d = {pipe_q[DEPTH-2:0], in_valid};

  // NOTE: this shift register is reset (unlike a data memory) because a stale bit would fire a result write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  assign out_valid = pipe_q[DEPTH-1];
  // Rows still in flight after this cycle's output stage has been written.
  assign any_valid = in_valid | (|pipe_q[DEPTH-2:0]);
endmodule

// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer: weight pop/load, UB vector feed and delayed result-SRAM writes.
module tpu_tile_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned ADDRESSSIZE = 10,
  parameter int unsigned MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int unsigned PIPE_LAT    = pipe_lat_of(MATRIX_SIZE),
  parameter int unsigned WLOAD_LAT   = wload_lat_of(MATRIX_SIZE),
  parameter int unsigned TILE_BW     = 6
) (
  input logic clk,
  input logic rstn,
  tpu_tile_sequencer_if.master bus
);
  localparam int unsigned WCW = (WLOAD_LAT > 1) ? $clog2(WLOAD_LAT) : 1;
  localparam logic [ADDRESSSIZE-1:0] ONE_A   = ADDRESSSIZE'(1);
  localparam logic [TILE_BW-1:0]     ONE_T   = TILE_BW'(1);
  localparam logic [WCW-1:0]         WL_LAST = WCW'(WLOAD_LAT - 1);

  seq_state_e             state_q, state_d;
  logic [ADDRESSSIZE-1:0] num_vec_q, num_vec_d, vec_cnt_q, vec_cnt_d;
  logic [ADDRESSSIZE-1:0] ub_ptr_q, ub_ptr_d, res_ptr_q, res_ptr_d;
  logic [TILE_BW-1:0]     tiles_q, tiles_d;
  logic [WCW-1:0]         wcnt_q, wcnt_d;
  logic fifo_re_q, fifo_re_d, we_rl_q, we_rl_d;
  logic busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic issue, res_we, pipe_busy;

  assign issue = (state_q == ST_FEED);

  tpu_valid_pipe #(.DEPTH(PIPE_LAT)) u_valid_pipe (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (issue),
    .out_valid(res_we),
    .any_valid(pipe_busy)
  );

  // NOTE: every _d takes its _q (or idle) value first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    num_vec_d = num_vec_q;
    vec_cnt_d = vec_cnt_q;
    ub_ptr_d  = ub_ptr_q;
    res_ptr_d = res_ptr_q;
    tiles_d   = tiles_q;
    wcnt_d    = wcnt_q;
    busy_d    = busy_q;
    cfg_err_d = cfg_err_q;
    fifo_re_d = 1'b0;
    we_rl_d   = 1'b0;
    done_d    = 1'b0;

    if (res_we) res_ptr_d = res_ptr_q + ONE_A;

    unique case (state_q)
      ST_IDLE: if (bus.start) begin
        num_vec_d = bus.cfg_num_vec;
        tiles_d   = bus.cfg_num_tiles;
        ub_ptr_d  = bus.cfg_ub_base;
        res_ptr_d = bus.cfg_res_base;
        cfg_err_d = 1'b0;
        if (bus.cfg_num_vec == '0 || bus.cfg_num_tiles == '0) begin
          cfg_err_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_FINISH;
        end else begin
          busy_d    = 1'b1;
          fifo_re_d = ~bus.fifo_empty;
          state_d   = ST_WREQ;
        end
      end
      // The pop is registered: the cycle it is high is the cycle we leave WREQ.
      ST_WREQ: if (fifo_re_q) begin
        we_rl_d = 1'b1;
        wcnt_d  = '0;
        state_d = ST_WLOAD;
      end else begin
        fifo_re_d = ~bus.fifo_empty;
      end
      ST_WLOAD: if (wcnt_q == WL_LAST) begin
        vec_cnt_d = '0;
        state_d   = ST_FEED;
      end else begin
        wcnt_d = wcnt_q + WCW'(1);
      end
      ST_FEED: begin
        ub_ptr_d = ub_ptr_q + ONE_A;
        if (vec_cnt_q == num_vec_q - ONE_A) state_d = ST_DRAIN;
        else                                vec_cnt_d = vec_cnt_q + ONE_A;
      end
      ST_DRAIN: if (!pipe_busy) begin
        if (tiles_q == ONE_T) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          tiles_d   = tiles_q - ONE_T;
          fifo_re_d = ~bus.fifo_empty;
          state_d   = ST_WREQ;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      num_vec_q <= '0;
      vec_cnt_q <= '0;
      ub_ptr_q  <= '0;
      res_ptr_q <= '0;
      tiles_q   <= '0;
      wcnt_q    <= '0;
      fifo_re_q <= 1'b0;
      we_rl_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_vec_q <= num_vec_d;
      vec_cnt_q <= vec_cnt_d;
      ub_ptr_q  <= ub_ptr_d;
      res_ptr_q <= res_ptr_d;
      tiles_q   <= tiles_d;
      wcnt_q    <= wcnt_d;
      fifo_re_q <= fifo_re_d;
      we_rl_q   <= we_rl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.fifo_read_enable = fifo_re_q;
  assign bus.we_rl            = we_rl_q;
  assign bus.ub_address       = ub_ptr_q;
  assign bus.res_write_enable = res_we;
  assign bus.res_address      = res_ptr_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.cfg_err          = cfg_err_q;
endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Scoreboard bench for tpu_tile_sequencer with MATRIX_SIZE=8 (WLOAD_LAT=8, PIPE_LAT=18).
module tb_tpu_tile_sequencer;
  localparam int W  = 8;
  localparam int PL = 18;

  typedef struct {
    int         cyc;
    logic [9:0] addr;
  } ev_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   t0  = 0;

  tpu_tile_sequencer_if #(.ADDRESSSIZE(10), .TILE_BW(6)) bus ();

  tpu_tile_sequencer #(.ADDRESSSIZE(10), .MATRIX_SIZE(8), .TILE_BW(6)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc - t0);
    end
  endtask

  // Scoreboard and reference model state.
  ev_t        ub_q[$];
  ev_t        wr_q[$];
  int         we_q[$];
  logic [9:0] m_ub, m_res;
  int         m_nv;
  int         first_pop_exp, exp_done, last_wr;
  int         pop_cnt, we_cnt, wr_cnt, done_cnt, done_rel;
  bit         done_seen;
  bit         mon_en = 1'b0;

  always @(negedge clk) if (mon_en) begin
    int  rel;
    ev_t e;
    rel = cyc - t0;
    if (bus.fifo_read_enable) begin
      pop_cnt++;
      if (pop_cnt == 1) check("pop_cycle", rel, first_pop_exp);
      else              check("pop_after_drain", (rel > last_wr) ? 1 : 0, 1);
      we_q.push_back(rel + 1);
      for (int k = 0; k < m_nv; k++) begin
        ub_q.push_back('{rel + 1 + W + k, m_ub});
        m_ub++;
        wr_q.push_back('{rel + 1 + W + PL + k, m_res});
        m_res++;
        exp_done = rel + 2 + W + PL + k;
      end
    end
    if (bus.we_rl) begin
      we_cnt++;
      if (we_q.size() == 0) check("we_rl_unexpected", 1, 0);
      else                  check("we_rl_cycle", rel, we_q.pop_front());
    end
    if (ub_q.size() != 0 && ub_q[0].cyc == rel) begin
      e = ub_q.pop_front();
      check("ub_address", bus.ub_address, e.addr);
    end
    if (bus.res_write_enable) begin
      wr_cnt++;
      last_wr = rel;
      check("wr_vs_we_rl", bus.we_rl, 0);
      if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = wr_q.pop_front();
        check("wr_address", bus.res_address, e.addr);
        check("wr_cycle", rel, e.cyc);
      end
    end
    if (bus.done) begin
      done_cnt++;
      done_rel  = rel;
      done_seen = 1'b1;
    end
  end

  task automatic launch();
    @(posedge clk);
    #1;
    t0        = cyc;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic setup(input logic [9:0] ub_base, input logic [9:0] res_base,
                       input logic [9:0] nv, input logic [5:0] tiles, input int stall);
    ub_q.delete();
    wr_q.delete();
    we_q.delete();
    pop_cnt   = 0;
    we_cnt    = 0;
    wr_cnt    = 0;
    done_cnt  = 0;
    done_seen = 1'b0;
    done_rel  = -1;
    last_wr   = -1000;
    m_ub      = ub_base;
    m_res     = res_base;
    m_nv      = int'(nv);
    first_pop_exp = (stall > 0) ? stall + 2 : 1;
    exp_done  = (nv == 0 || tiles == 0) ? 1 : -1;
    bus.cfg_ub_base   = ub_base;
    bus.cfg_res_base  = res_base;
    bus.cfg_num_vec   = nv;
    bus.cfg_num_tiles = tiles;
    bus.fifo_empty    = (stall > 0);
  endtask

  task automatic run(input string name, input logic [9:0] ub_base, input logic [9:0] res_base,
                     input logic [9:0] nv, input logic [5:0] tiles, input int stall);
    bit err;
    int n_exp;
    err   = (nv == 0 || tiles == 0);
    n_exp = err ? 0 : int'(tiles);
    setup(ub_base, res_base, nv, tiles, stall);
    launch();
    @(negedge clk);
    check({name, ":cfg_err_c1"}, bus.cfg_err, err);
    check({name, ":busy_c1"}, bus.busy, !err);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      check({name, ":stall_busy"}, bus.busy, 1);
      check({name, ":stall_pops"}, pop_cnt, 0);
      check({name, ":stall_we_rl"}, we_cnt, 0);
      bus.fifo_empty = 1'b0;
    end
    for (int i = 0; i < 3000 && !done_seen; i++) @(posedge clk);
    check({name, ":done_seen"}, done_seen, 1);
    repeat (3) @(posedge clk);
    #1;
    check({name, ":done_cycle"}, done_rel, exp_done);
    check({name, ":done_count"}, done_cnt, 1);
    check({name, ":pops"}, pop_cnt, n_exp);
    check({name, ":we_rl_count"}, we_cnt, n_exp);
    check({name, ":writes"}, wr_cnt, n_exp * m_nv);
    check({name, ":left_wr"}, wr_q.size(), 0);
    check({name, ":left_ub"}, ub_q.size(), 0);
    check({name, ":busy_end"}, bus.busy, 0);
    check({name, ":cfg_err_end"}, bus.cfg_err, err);
  endtask

  function automatic logic [31:0] outs();
    return {3'b0, bus.fifo_read_enable, bus.we_rl, bus.ub_address, bus.res_write_enable,
            bus.res_address, bus.busy, bus.done, bus.cfg_err};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn              = 1'b0;
    bus.start         = 1'b0;
    bus.cfg_ub_base   = '0;
    bus.cfg_res_base  = '0;
    bus.cfg_num_vec   = '0;
    bus.cfg_num_tiles = '0;
    bus.fifo_empty    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 0);
    rstn   = 1'b1;
    mon_en = 1'b1;

    run("basic", 10'h010, 10'h100, 10'd8, 6'd1, 0);
    run("multi", 10'h010, 10'h100, 10'd4, 6'd3, 0);
    run("stall", 10'h020, 10'h200, 10'd4, 6'd1, 20);
    run("cfg_err", 10'h010, 10'h100, 10'd0, 6'd2, 0);
    run("after_err", 10'h010, 10'h100, 10'd8, 6'd1, 0);
    run("wrap", 10'h030, 10'h3FE, 10'd4, 6'd1, 0);

    // Reset in the middle of FEED: outputs clear at once and no write follows.
    setup(10'h010, 10'h100, 10'd8, 6'd1, 0);
    launch();
    repeat (11) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("midfeed_reset_outputs", outs(), 0);
    ub_q.delete();
    wr_q.delete();
    we_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("midfeed_no_writes", wr_cnt, 0);
    check("midfeed_idle", outs(), 0);

    run("post_reset", 10'h010, 10'h100, 10'd8, 6'd1, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
